// File: rtl/game_set_pkg.sv
// Shared constants and types for the "GAME SET" banner sprite fetch.
// Holds the default banner geometry, the animation timing, the derived
// slide target and ROM address width, and the animation state type.
package game_set_pkg;

  localparam int unsigned IMG_W       = 160;
  localparam int unsigned IMG_H       = 40;
  localparam int unsigned SCREEN_W    = 640;
  localparam int unsigned Y_POS       = 220;
  localparam int unsigned SLIDE_STEP  = 8;
  localparam int unsigned HOLD_FRAMES = 120;
  localparam int unsigned BLINK_HALF  = 8;
  localparam int unsigned TRANSP_IDX  = 0;

  // Final resting column: banner centred horizontally
  localparam int unsigned X_TGT  = (SCREEN_W - IMG_W) / 2;
  localparam int unsigned ADDR_W = $clog2(IMG_W * IMG_H);

  localparam int unsigned XW = 11;                    // x_pos / box maths width
  localparam int unsigned DW = 10;                    // beam coordinate width
  localparam int unsigned PW = 3;                     // palette index width
  localparam int unsigned CW = $clog2(HOLD_FRAMES);   // HOLD frame counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SLIDE = 2'd1,
    HOLD  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/game_set_sprite_fetch_if.sv
// Sprite ROM bus between the banner fetch logic and its synchronous ROM.
//   rom_addr : word address driven by the fetch block (master)
//   rom_q    : palette index returned by the ROM one cycle after rom_addr
interface game_set_sprite_fetch_if;
  import game_set_pkg::*;

  logic [ADDR_W-1:0] rom_addr;
  logic [PW-1:0]     rom_q;

  modport master (output rom_addr, input rom_q);
  modport slave  (input rom_addr, output rom_q);

endinterface

// File: rtl/sprite_addr_gen.sv
// Combinational box test and ROM address for a rectangular sprite whose
// left edge sits at x_pos and top edge at Y_POS.
//   drawx, drawy : beam position
//   x_pos        : current sprite left column (may extend past the screen)
//   in_box_c     : beam lies inside the sprite rectangle
//   addr_c       : row-major sprite address, 0 outside the box
module sprite_addr_gen
  import game_set_pkg::*;
#(
  parameter int unsigned SPR_W   = IMG_W,
  parameter int unsigned SPR_H   = IMG_H,
  parameter int unsigned SPR_Y   = Y_POS,
  parameter int unsigned SPR_AW  = ADDR_W
) (
  input  logic [DW-1:0]     drawx,
  input  logic [DW-1:0]     drawy,
  input  logic [XW-1:0]     x_pos,
  output logic              in_box_c,
  output logic [SPR_AW-1:0] addr_c
);

  logic [XW-1:0] px;
  logic [XW-1:0] py;
  logic [XW-1:0] dx;
  logic [XW-1:0] dy;

  // All comparisons in XW bits so x_pos + SPR_W cannot wrap
  always_comb begin
    px       = XW'(drawx);
    py       = XW'(drawy);
    dx       = px - x_pos;
    dy       = py - XW'(SPR_Y);
    in_box_c = (px >= x_pos) && (px < x_pos + XW'(SPR_W)) &&
               (py >= XW'(SPR_Y)) && (py < XW'(SPR_Y + SPR_H));
    addr_c   = '0;
    if (in_box_c) begin
      addr_c = SPR_AW'(SPR_AW'(dy) * SPR_AW'(SPR_W)) + SPR_AW'(dx);
    end
  end

endmodule

// File: rtl/game_set_sprite_fetch.sv
// "GAME SET" banner: slide-in / blink / hold animation and sprite fetch.
// Converts the beam position into a palette index with a fixed two-cycle
// latency, through an external synchronous sprite ROM.
//   Clk, Reset  : single clock, synchronous active-high reset
//   frame_start : one pulse per frame (blanking); advances the animation
//   start       : (re)starts the animation from off-screen right
//   DrawX/DrawY : beam column / row
//   rom         : sprite ROM bus (address out, data in one cycle later)
//   pal_index   : palette index, 0 whenever pixel_on is 0
//   pixel_on    : opaque, visible banner pixel
//   busy / done : animation running / finished
module game_set_sprite_fetch
  import game_set_pkg::*;
(
  input  logic                    Clk,
  input  logic                    Reset,
  input  logic                    frame_start,
  input  logic                    start,
  input  logic [DW-1:0]           DrawX,
  input  logic [DW-1:0]           DrawY,
  game_set_sprite_fetch_if.master rom,
  output logic [PW-1:0]           pal_index,
  output logic                    pixel_on,
  output logic                    busy,
  output logic                    done
);

  state_t          state;
  logic [XW-1:0]   x_pos;
  logic [CW-1:0]   frame_cnt;
  logic [CW-1:0]   blink_phase;

  logic              in_box_c;
  logic [ADDR_W-1:0] addr_c;
  logic              vis_c;
  logic              pix_next_c;

  logic in_box_q;
  logic vis_q;
  logic in_box_d;
  logic vis_d;

  sprite_addr_gen u_addr (
    .drawx    (DrawX),
    .drawy    (DrawY),
    .x_pos    (x_pos),
    .in_box_c (in_box_c),
    .addr_c   (addr_c)
  );

  // Banner visibility: blinks in HOLD on BLINK_HALF-frame half periods
  always_comb begin
    blink_phase = CW'(frame_cnt / CW'(BLINK_HALF));
    vis_c       = (state == SLIDE) || (state == DONE) ||
                  ((state == HOLD) && !blink_phase[0]);
    pix_next_c  = in_box_d && vis_d && (rom.rom_q != PW'(TRANSP_IDX));
  end

  // Animation FSM; start wins over a coincident frame_start
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      x_pos     <= XW'(SCREEN_W);
      frame_cnt <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (start) begin
      state     <= SLIDE;
      x_pos     <= XW'(SCREEN_W);
      frame_cnt <= '0;
      busy      <= 1'b1;
      done      <= 1'b0;
    end else if (frame_start) begin
      case (state)
        SLIDE: begin
          // x_pos - SLIDE_STEP <= X_TGT, rearranged to avoid underflow
          if (x_pos <= XW'(X_TGT + SLIDE_STEP)) begin
            x_pos <= XW'(X_TGT);
            state <= HOLD;
          end else begin
            x_pos <= x_pos - XW'(SLIDE_STEP);
          end
        end
        HOLD: begin
          if (frame_cnt == CW'(HOLD_FRAMES - 1)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            frame_cnt <= frame_cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Fetch pipeline: address stage, ROM stage, registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rom.rom_addr <= '0;
      in_box_q     <= 1'b0;
      vis_q        <= 1'b0;
      in_box_d     <= 1'b0;
      vis_d        <= 1'b0;
      pixel_on     <= 1'b0;
      pal_index    <= '0;
    end else begin
      rom.rom_addr <= addr_c;
      in_box_q     <= in_box_c;
      vis_q        <= vis_c;
      in_box_d     <= in_box_q;
      vis_d        <= vis_q;
      pixel_on     <= pix_next_c;
      pal_index    <= pix_next_c ? rom.rom_q : '0;
    end
  end

endmodule

// File: tb/tb_game_set_sprite_fetch.sv
// Directed bench for game_set_sprite_fetch: reset, slide, blink timing,
// pipeline latency, box edges, transparency, DONE hold and restart.
module tb_game_set_sprite_fetch;
  import game_set_pkg::*;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_start;
  logic       start;
  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic [2:0] pal_index;
  logic       pixel_on;
  logic       busy;
  logic       done;
  logic [2:0] rom_val;

  int n_assert = 0;
  int n_fail   = 0;

  game_set_sprite_fetch_if bus ();

  game_set_sprite_fetch dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_start (frame_start),
    .start       (start),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom         (bus.master),
    .pal_index   (pal_index),
    .pixel_on    (pixel_on),
    .busy        (busy),
    .done        (done)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM model: every word holds rom_val, one cycle of latency
  always @(posedge Clk) bus.rom_q <= rom_val;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      #1;
    end
  endtask

  task automatic frame();
    frame_start = 1'b1;
    step(1);
    frame_start = 1'b0;
  endtask

  task automatic pix(input string tag, input logic on, input logic [2:0] idx);
    chk({tag, "_on"}, 32'(pixel_on), 32'(on));
    chk({tag, "_idx"}, 32'(pal_index), 32'(idx));
  endtask

  initial begin
    rom_val     = 3'd5;
    Reset       = 1'b1;
    start       = 1'b0;
    frame_start = 1'b0;
    DrawX       = 10'd0;
    DrawY       = 10'd0;
    step(2);
    Reset = 1'b0;
    chk("por_state", 32'(dut.state), 32'(IDLE));
    chk("por_xpos", 32'(dut.x_pos), 32'd640);
    chk("por_busy", 32'(busy), 32'd0);
    chk("por_done", 32'(done), 32'd0);
    pix("por_pix", 1'b0, 3'd0);

    // Reset in the middle of a slide
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int k = 0; k < 5; k++) frame();
    chk("mid_xpos", 32'(dut.x_pos), 32'd600);
    DrawX = 10'd610;
    DrawY = 10'd225;
    step(3);
    pix("mid_pix", 1'b1, 3'd5);
    Reset = 1'b1;
    step(2);
    Reset = 1'b0;
    chk("rst_state", 32'(dut.state), 32'(IDLE));
    chk("rst_xpos", 32'(dut.x_pos), 32'd640);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_addr", 32'(bus.rom_addr), 32'd0);
    pix("rst_pix", 1'b0, 3'd0);
    DrawX = 10'd0;
    DrawY = 10'd0;

    // Full slide: 640 -> 240 in 50 frames
    start = 1'b1;
    step(1);
    start = 1'b0;
    chk("slide0_state", 32'(dut.state), 32'(SLIDE));
    chk("slide0_xpos", 32'(dut.x_pos), 32'd640);
    chk("slide0_busy", 32'(busy), 32'd1);
    for (int k = 1; k <= 50; k++) begin
      frame();
      chk($sformatf("slide%0d_xpos", k), 32'(dut.x_pos), 32'(640 - 8 * k));
      chk($sformatf("slide%0d_state", k), 32'(dut.state), (k == 50) ? 32'(HOLD) : 32'(SLIDE));
      chk($sformatf("slide%0d_busy", k), 32'(busy), 32'd1);
    end

    // Single in-box pixel: address next cycle, outputs exactly 2 cycles after sampling
    step(3);
    DrawX = 10'd245;
    DrawY = 10'd221;
    step(1);
    chk("lat_addr", 32'(bus.rom_addr), 32'd165);
    pix("lat_c1", 1'b0, 3'd0);
    DrawX = 10'd0;
    DrawY = 10'd0;
    step(1);
    pix("lat_c2", 1'b0, 3'd0);
    step(1);
    pix("lat_c3", 1'b1, 3'd5);
    step(1);
    pix("lat_c4", 1'b0, 3'd0);

    // Top-left corner, then the blink off/on phases
    DrawX = 10'd240;
    DrawY = 10'd220;
    step(1);
    chk("corner_addr", 32'(bus.rom_addr), 32'd0);
    step(2);
    pix("corner_pix", 1'b1, 3'd5);
    for (int k = 0; k < 8; k++) frame();
    step(3);
    pix("blink8", 1'b0, 3'd0);
    for (int k = 0; k < 7; k++) frame();
    step(3);
    pix("blink15", 1'b0, 3'd0);
    frame();
    step(3);
    pix("blink16", 1'b1, 3'd5);

    // Transparent colour key and box edges
    rom_val = 3'd0;
    step(3);
    pix("transp", 1'b0, 3'd0);
    rom_val = 3'd5;
    DrawX   = 10'd239;
    step(1);
    chk("left_addr", 32'(bus.rom_addr), 32'd0);
    step(2);
    pix("left_pix", 1'b0, 3'd0);
    DrawX = 10'd400;
    step(1);
    chk("right_addr", 32'(bus.rom_addr), 32'd0);
    step(2);
    pix("right_pix", 1'b0, 3'd0);
    DrawX = 10'd399;
    DrawY = 10'd259;
    step(1);
    chk("last_addr", 32'(bus.rom_addr), 32'd6399);
    step(2);
    pix("last_pix", 1'b1, 3'd5);
    DrawX = 10'd240;
    DrawY = 10'd260;
    step(1);
    chk("below_addr", 32'(bus.rom_addr), 32'd0);
    step(2);
    pix("below_pix", 1'b0, 3'd0);

    // Finish HOLD: frame_cnt 16 -> 119 still HOLD, next frame -> DONE
    DrawY = 10'd220;
    for (int k = 17; k <= 119; k++) frame();
    chk("hold119_state", 32'(dut.state), 32'(HOLD));
    chk("hold119_busy", 32'(busy), 32'd1);
    chk("hold119_done", 32'(done), 32'd0);
    frame();
    chk("done_state", 32'(dut.state), 32'(DONE));
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_done", 32'(done), 32'd1);
    step(3);
    pix("done_pix", 1'b1, 3'd5);
    for (int k = 0; k < 8; k++) frame();
    step(3);
    pix("steady_pix", 1'b1, 3'd5);
    chk("steady_state", 32'(dut.state), 32'(DONE));

    // start and frame_start together: restart, no step taken
    start       = 1'b1;
    frame_start = 1'b1;
    step(1);
    start       = 1'b0;
    frame_start = 1'b0;
    chk("restart_state", 32'(dut.state), 32'(SLIDE));
    chk("restart_xpos", 32'(dut.x_pos), 32'd640);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    frame();
    chk("restart_step", 32'(dut.x_pos), 32'd632);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
